sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'd1024, byte address mapped to SRAM word 0.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra SRAM cycles per half-word access (0..7).
REQ-003 SHALL have parameter SRAM_WORDS, default 65536, number of 32-bit words in the SRAM window.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 rd_en  in  1  pipeline memory-read request, level, held while ready=0.
REQ-007 wr_en  in  1  pipeline memory-write request, level, held while ready=0.
REQ-008 address  in  32  byte address from execute stage; bits [1:0] ignored.
REQ-009 write_data  in  32  store data.
REQ-010 read_data  out  32  load result, registered.
REQ-011 ready  out  1  high = access complete or idle; low = pipeline SHALL freeze.
REQ-012 sram_addr  out  18  half-word address {word_index[16:0], half_sel}.
REQ-013 sram_dq_out  out  16  write half-word; sram_dq_oe out 1 drive enable.
REQ-014 sram_dq_in  in  16  read half-word from SRAM.
REQ-015 sram_we_n  out  1  active-low write strobe; sram_oe_n out 1 active-low output enable.

Function
REQ-016 word_index SHALL be (address - BASE_ADDR) >> 2, 32-bit unsigned subtraction.
REQ-017 Access SHALL be in range iff address >= BASE_ADDR and word_index < SRAM_WORDS.
REQ-018 FSM states SHALL be IDLE, LOW, HIGH, DONE.
REQ-019 IDLE -> LOW when rd_en or wr_en sampled high; otherwise stay IDLE.
REQ-020 rd_en and wr_en both high SHALL be treated as a write.
REQ-021 LOW SHALL last WAIT_CYCLES+1 cycles accessing half_sel=0 (bits [15:0]), then -> HIGH.
REQ-022 HIGH SHALL last WAIT_CYCLES+1 cycles accessing half_sel=1 (bits [31:16]), then -> DONE.
REQ-023 DONE SHALL last exactly one cycle, then -> IDLE unconditionally.
REQ-024 ready SHALL be combinational: (state==DONE) or (state==IDLE and !rd_en and !wr_en).
REQ-025 Total stall for one access SHALL be 2*(WAIT_CYCLES+1)+1 cycles of ready=0; ready=1 in DONE.
REQ-026 Write: sram_dq_oe=1 and sram_we_n=0 throughout LOW and HIGH; sram_oe_n=1.
REQ-027 Read: sram_oe_n=0 throughout LOW and HIGH; sram_we_n=1, sram_dq_oe=0.
REQ-028 Read half-words SHALL be captured from sram_dq_in on the last cycle of LOW and HIGH respectively.
REQ-029 read_data SHALL update only at read completion and hold its value until the next read completes.
REQ-030 Out-of-range write SHALL keep sram_we_n=1; out-of-range read SHALL load read_data=0; latency unchanged.
REQ-031 In IDLE and DONE, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0.
REQ-032 Request still asserted in the cycle after DONE SHALL start a new access (pipeline delivered next op).

Reset
REQ-033 rst SHALL force state=IDLE, wait counter=0, read_data=0 immediately, independent of clk.
REQ-034 During rst: sram_we_n=1, sram_oe_n=1, sram_dq_oe=0; ready follows REQ-024.
REQ-035 rst mid-access SHALL abort it; partial write may leave only the low half written; no completion signalled.

Structure
REQ-036 Shared package sram_pkg SHALL hold the state enum, SRAM_AW=18, DEFAULT_BASE_ADDR=1024.
REQ-037 Wait counter SHALL be one sub-module, sram_wait_timer (load, count down, done pulse).

Verification
REQ-038 WAIT_CYCLES=1, write addr 1024 data 32'hDEADBEEF -> sram_addr 0 gets 16'hBEEF, 1 gets 16'hDEAD; ready low 5 cycles.
REQ-039 Read addr 1024 after REQ-038, SRAM model returning stored data -> read_data=32'hDEADBEEF in DONE cycle.
REQ-040 rd_en and wr_en both high, addr 1028, data 32'h12345678 -> write occurs to sram_addr 2/3, no sram_oe_n low.
REQ-041 Read addr 1020 (below base) -> read_data=0, sram_we_n never low, ready low 5 cycles.
REQ-042 rst asserted in HIGH of a write -> outputs idle within same cycle, next read of that word returns new low half, old high half.
REQ-043 Back-to-back reads addr 1024 then 1028 with request held -> two DONE pulses 6 cycles apart, read_data updates each.

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state encoding and constants for the SRAM controller
package sram_pkg;

    localparam int          SRAM_AW           = 18;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } sram_state_e;

endpackage

// File: rtl/sram_wait_timer.sv
// rtl/sram_wait_timer.sv - loadable down-counter; done_o marks the final cycle of a phase
module sram_wait_timer #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          done_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - 32-bit pipeline memory port onto a 16-bit asynchronous SRAM
module sram_ctrl
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_CYCLES = 1,
    parameter int          SRAM_WORDS  = 65536
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam logic [2:0]  WAIT_LD   = 3'(WAIT_CYCLES);
    localparam logic [31:0] WORDS_LIM = 32'(SRAM_WORDS);

    sram_state_e          state_q, state_d;
    logic                 is_write_q, is_write_d;
    logic                 in_range_q, in_range_d;
    logic [SRAM_AW-2:0]   word_idx_q, word_idx_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [15:0]          rdata_lo_q, rdata_lo_d;
    logic [31:0]          read_data_q, read_data_d;

    logic [31:0] word_full;
    logic        req_in_range;
    logic        tmr_load;
    logic        tmr_done;
    logic        active;
    logic        half_sel;

    // Unsigned wrap below BASE_ADDR is caught by the explicit >= test.
    assign word_full    = (address - BASE_ADDR) >> 2;
    assign req_in_range = (address >= BASE_ADDR) && (word_full < WORDS_LIM);

    sram_wait_timer #(.CW(3)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (WAIT_LD),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        in_range_d  = in_range_q;
        word_idx_d  = word_idx_q;
        wdata_d     = wdata_q;
        rdata_lo_d  = rdata_lo_q;
        read_data_d = read_data_q;
        tmr_load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_en || wr_en) begin
                    state_d    = ST_LOW;
                    tmr_load   = 1'b1;
                    is_write_d = wr_en;
                    in_range_d = req_in_range;
                    word_idx_d = word_full[SRAM_AW-2:0];
                    wdata_d    = write_data;
                end
            end
            ST_LOW: begin
                if (tmr_done) begin
                    state_d    = ST_HIGH;
                    tmr_load   = 1'b1;
                    rdata_lo_d = sram_dq_in;
                end
            end
            ST_HIGH: begin
                if (tmr_done) begin
                    state_d = ST_DONE;
                    if (!is_write_q) begin
                        read_data_d = in_range_q ? {sram_dq_in, rdata_lo_q} : 32'd0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            is_write_q  <= 1'b0;
            in_range_q  <= 1'b0;
            word_idx_q  <= '0;
            wdata_q     <= '0;
            rdata_lo_q  <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            in_range_q  <= in_range_d;
            word_idx_q  <= word_idx_d;
            wdata_q     <= wdata_d;
            rdata_lo_q  <= rdata_lo_d;
            read_data_q <= read_data_d;
        end
    end

    assign active   = (state_q == ST_LOW) || (state_q == ST_HIGH);
    assign half_sel = (state_q == ST_HIGH);

    // Strobes only reach the SRAM for in-range accesses; timing is identical either way.
    assign sram_addr   = {word_idx_q, half_sel};
    assign sram_dq_out = half_sel ? wdata_q[31:16] : wdata_q[15:0];
    assign sram_dq_oe  = active && is_write_q && in_range_q;
    assign sram_we_n   = !(active && is_write_q && in_range_q);
    assign sram_oe_n   = !(active && !is_write_q && in_range_q);

    assign ready     = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !rd_en && !wr_en);
    assign read_data = read_data_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed and randomized checks of sram_ctrl against a word-level model
module tb_sram_ctrl;

    localparam int          W     = 1;
    localparam int          WORDS = 256;
    localparam logic [31:0] BASE  = 32'd1024;
    localparam int          STALL = 2 * (W + 1) + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n, sram_oe_n;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic mem_init;

    logic [15:0] sram    [0:(1<<18)-1];
    logic [31:0] ref_mem [0:WORDS-1];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    sram_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(W), .SRAM_WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 40503 + 4660);
    endfunction

    // Asynchronous SRAM device: reads while oe_n low, latches a half-word on each clocked write strobe.
    assign sram_dq_in = sram_oe_n ? 16'h5A5A : sram[sram_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_init) begin
            for (int i = 0; i < 2 * WORDS; i++) sram[18'(i)] <= pat(i);
        end else if (!sram_we_n && sram_dq_oe) begin
            sram[sram_addr] <= sram_dq_out;
        end
    end

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < WORDS);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input bit hold, output int stall, output bit saw_we, output bit saw_oe,
                          output bit saw_dqoe, output int done_cyc);
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        stall = 0; saw_we = 0; saw_oe = 0; saw_dqoe = 0;
        #1;
        while (!ready && stall < 40) begin
            stall++;
            if (!sram_we_n) saw_we = 1;
            if (!sram_oe_n) saw_oe = 1;
            if (sram_dq_oe) saw_dqoe = 1;
            @(negedge clk); #1;
        end
        done_cyc = cyc;
        if (!hold) begin
            rd_en = 0; wr_en = 0;
        end
    endtask

    initial begin
        int          st, dc, dc2;
        bit          swe, soe, sdq;
        logic [31:0] a, d, e;
        int          kind, r;
        bit          inr;

        rst = 1; rd_en = 0; wr_en = 0; address = 0; write_data = 0; mem_init = 1; last_rd = 0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = {pat(2 * i + 1), pat(2 * i)};
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        rd_en = 1; #1;
        chk("rst_ready_req", 32'(ready), 32'd0);
        rd_en = 0; mem_init = 0;
        @(negedge clk); rst = 0;
        @(negedge clk);

        // Write DEADBEEF to the first word.
        access(0, 1, 32'd1024, 32'hDEADBEEF, 0, st, swe, soe, sdq, dc);
        chk("wr0_stall", 32'(st), 32'(STALL));
        chk("wr0_we_seen", 32'(swe), 32'd1);
        chk("wr0_dqoe_seen", 32'(sdq), 32'd1);
        chk("wr0_no_oe", 32'(soe), 32'd0);
        chk("wr0_rd_hold", read_data, 32'd0);
        ref_mem[0] = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr0_lo_half", 32'(sram[0]), 32'h0000BEEF);
        chk("wr0_hi_half", 32'(sram[1]), 32'h0000DEAD);

        access(1, 0, 32'd1024, 32'd0, 0, st, swe, soe, sdq, dc);
        chk("rd0_data", read_data, 32'hDEADBEEF);
        chk("rd0_stall", 32'(st), 32'(STALL));
        chk("rd0_no_we", 32'(swe), 32'd0);
        chk("rd0_oe_seen", 32'(soe), 32'd1);
        last_rd = 32'hDEADBEEF;
        @(negedge clk);

        // Both requests high behaves as a write.
        access(1, 1, 32'd1028, 32'h12345678, 0, st, swe, soe, sdq, dc);
        chk("both_stall", 32'(st), 32'(STALL));
        chk("both_no_oe", 32'(soe), 32'd0);
        chk("both_rd_hold", read_data, last_rd);
        ref_mem[1] = 32'h12345678;
        @(negedge clk);
        chk("both_lo_half", 32'(sram[2]), 32'h00005678);
        chk("both_hi_half", 32'(sram[3]), 32'h00001234);

        access(1, 0, 32'd1020, 32'd0, 0, st, swe, soe, sdq, dc);
        chk("below_data", read_data, 32'd0);
        chk("below_no_we", 32'(swe), 32'd0);
        chk("below_stall", 32'(st), 32'(STALL));
        last_rd = 0;
        @(negedge clk);

        access(1, 0, BASE + 32'(4 * WORDS), 32'd0, 0, st, swe, soe, sdq, dc);
        chk("top_oor_data", read_data, 32'd0);
        @(negedge clk);
        access(1, 0, BASE + 32'(4 * (WORDS - 1)) + 32'd3, 32'd0, 0, st, swe, soe, sdq, dc);
        chk("top_last_data", read_data, ref_mem[WORDS - 1]);
        last_rd = ref_mem[WORDS - 1];
        @(negedge clk);

        // Back-to-back reads with the request held through DONE.
        access(1, 0, 32'd1024, 32'd0, 1, st, swe, soe, sdq, dc);
        chk("b2b_first", read_data, 32'hDEADBEEF);
        @(negedge clk);
        access(1, 0, 32'd1028, 32'd0, 0, st, swe, soe, sdq, dc2);
        chk("b2b_second", read_data, 32'h12345678);
        chk("b2b_gap", 32'(dc2 - dc), 32'd6);
        chk("b2b_stall", 32'(st), 32'(STALL));
        last_rd = 32'h12345678;
        @(negedge clk);

        // Reset during the high half of a write leaves only the low half updated.
        e = {ref_mem[2][31:16], 16'h2222};
        wr_en = 1; address = 32'd1032; write_data = 32'h11112222;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_in_high", 32'({sram_we_n, sram_addr}), 32'({1'b0, 17'd2, 1'b1}));
        rst = 1; #1;
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_oe_n", 32'(sram_oe_n), 32'd1);
        chk("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("abort_read_data", read_data, 32'd0);
        wr_en = 0; #1;
        chk("abort_ready", 32'(ready), 32'd1);
        ref_mem[2] = e;
        last_rd = 0;
        @(negedge clk); rst = 0;
        @(negedge clk);
        access(1, 0, 32'd1032, 32'd0, 0, st, swe, soe, sdq, dc);
        chk("abort_readback", read_data, e);
        last_rd = e;
        @(negedge clk);

        for (int n = 0; n < 16; n++) begin
            kind = $urandom_range(0, 2);
            r    = $urandom_range(0, 9);
            if (r == 0)      a = BASE - 32'(4 * $urandom_range(1, 8));
            else if (r == 1) a = BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 4));
            else if (r == 2) a = BASE + 32'(4 * (WORDS - 1));
            else             a = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
            a   = a + 32'($urandom_range(0, 3));
            d   = $urandom;
            inr = in_rng(a);
            access(kind != 1, kind != 0, a, d, 0, st, swe, soe, sdq, dc);
            chk("rnd_stall", 32'(st), 32'(STALL));
            if (kind == 0) begin
                e = inr ? ref_mem[(a - BASE) >> 2] : 32'd0;
                chk("rnd_read", read_data, e);
                chk("rnd_read_no_we", 32'(swe), 32'd0);
                last_rd = e;
            end else begin
                chk("rnd_write_hold", read_data, last_rd);
                chk("rnd_write_we", 32'(swe), 32'(inr));
                chk("rnd_write_no_oe", 32'(soe), 32'd0);
                if (inr) ref_mem[(a - BASE) >> 2] = d;
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
